note_player: RTL and testbench

NOTE_PLAYER -- requirements
Module: note_player

---
 rtl/note_pkg.sv | 43 ++++
 rtl/note_player_if.sv | 17 +
 rtl/note_player_tone_gen.sv | 29 ++
 rtl/note_player.sv | 141 ++++++++++++++
 tb/tb_note_player.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/note_pkg.sv
// Shared definitions for the note player: state encoding, note byte layout,
// pitch half-period table (12 MHz clock) and note-count helper.
package note_pkg;
  localparam int         MAX_NOTES = 120;
  localparam int         BUF_W     = 8 * MAX_NOTES;
  localparam logic [7:0] NOTE_TERM = 8'h1F;
  localparam int         HP_W      = 15;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_TONE, S_GAP, S_FINISH} state_e;

  typedef struct packed {
    logic [3:0] pitch;
    logic [3:0] dur;
  } note_t;

  // Half period in clocks for C4..B5 (white keys); 0 for rest codes.
  function automatic logic [HP_W-1:0] pitch_half_period(input logic [3:0] pitch);
    case (pitch)
      4'd1:    return 15'd22933;
      4'd2:    return 15'd20432;
      4'd3:    return 15'd18202;
      4'd4:    return 15'd17181;
      4'd5:    return 15'd15306;
      4'd6:    return 15'd13636;
      4'd7:    return 15'd12149;
      4'd8:    return 15'd11467;
      4'd9:    return 15'd10216;
      4'd10:   return 15'd9101;
      4'd11:   return 15'd8590;
      4'd12:   return 15'd7653;
      4'd13:   return 15'd6818;
      4'd14:   return 15'd6074;
      default: return '0;
    endcase
  endfunction

  // Received length includes the terminator byte.
  function automatic logic [6:0] note_count(input logic [9:0] len);
    if (len == '0) return '0;
    if ((len - 10'd1) > 10'(MAX_NOTES)) return 7'(MAX_NOTES);
    return 7'(len - 10'd1);
  endfunction
endpackage

// File: rtl/note_player_if.sv
// Song-in / playback-out bundle between the UART receive stage and the player.
interface note_player_if;
  import note_pkg::*;
  logic             rx_done;
  logic [9:0]       data_length;
  logic [BUF_W-1:0] data_buffer;
  logic             stop;
  logic             buzzer;
  logic             busy;
  logic [6:0]       note_idx;
  logic             done;

  modport master (output rx_done, data_length, data_buffer, stop,
                  input  buzzer, busy, note_idx, done);
  modport slave  (input  rx_done, data_length, data_buffer, stop,
                  output buzzer, busy, note_idx, done);
endinterface

// File: rtl/note_player_tone_gen.sv
// Square-wave generator: toggles every half_period clocks while enabled;
// clr restarts the waveform low.
module tone_gen
  import note_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clr,
  input  logic [HP_W-1:0] half_period,
  output logic            buzzer
);
  logic [HP_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      buzzer <= 1'b0;
    end else if (!en || clr) begin
      cnt    <= '0;
      buzzer <= 1'b0;
    end else if (cnt == half_period - 1'b1) begin
      cnt    <= '0;
      buzzer <= ~buzzer;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/note_player.sv
// Plays a captured song of pitch/duration bytes on a buzzer.
// Define NOTE_PLAYER_GAP_EN to insert GAP_CYCLES of silence between notes.
module note_player
  import note_pkg::*;
#(
  parameter int BEAT_CYCLES = 1500000,
  parameter int GAP_CYCLES  = 120000
) (
  input  logic         clk,
  input  logic         rst,
  note_player_if.slave np
);
  localparam int CW = $clog2(BEAT_CYCLES * 16 + 1);

  state_e           state, state_nx;
  logic [BUF_W-1:0] cap_buf;
  logic [9:0]       cap_len;
  logic [6:0]       note_idx, idx_nx, count, sel;
  logic [CW-1:0]    cyc, cyc_nx, dur_end;
  note_t            note;
  logic             capture, note_end, last_note, tone_en;

  assign capture   = np.rx_done && !np.stop;
  assign count     = note_count(cap_len);
  // First received note sits in the highest occupied byte.
  assign sel       = count - 7'd1 - note_idx;
  assign note      = note_t'(cap_buf[{sel, 3'b000} +: 8]);
  assign dur_end   = CW'((int'(note.dur) + 1) * BEAT_CYCLES - 1);
  assign note_end  = (state == S_TONE) && (cyc == dur_end);
  assign last_note = (note_idx == count - 7'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_buf <= '0;
      cap_len <= '0;
    end else if (capture) begin
      cap_buf <= np.data_buffer;
      cap_len <= np.data_length;
    end
  end

`ifdef NOTE_PLAYER_GAP_EN
  localparam int GW = $clog2(GAP_CYCLES + 1);
  logic [GW-1:0] gap_cnt;
  logic          gap_end;

  assign gap_end = (state == S_GAP) && (gap_cnt == GW'(GAP_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             gap_cnt <= '0;
    else if (state == S_GAP && !gap_end) gap_cnt <= gap_cnt + 1'b1;
    else                                 gap_cnt <= '0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      note_idx <= '0;
      cyc      <= '0;
    end else begin
      state    <= state_nx;
      note_idx <= idx_nx;
      cyc      <= cyc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = note_idx;
    cyc_nx   = cyc + 1'b1;
    case (state)
      S_IDLE: cyc_nx = '0;
      S_LOAD: begin
        cyc_nx   = '0;
        state_nx = (count != '0) ? S_TONE : S_FINISH;
      end
      S_TONE: begin
        if (note_end) begin
          cyc_nx = '0;
          if (last_note) state_nx = S_FINISH;
          else begin
`ifdef NOTE_PLAYER_GAP_EN
            state_nx = S_GAP;
`else
            idx_nx = note_idx + 1'b1;
`endif
          end
        end
      end
`ifdef NOTE_PLAYER_GAP_EN
      S_GAP: begin
        cyc_nx = '0;
        if (gap_end) begin
          state_nx = S_TONE;
          idx_nx   = note_idx + 1'b1;
        end
      end
`endif
      S_FINISH: begin
        cyc_nx   = '0;
        idx_nx   = '0;
        state_nx = S_IDLE;
      end
      default: begin
        cyc_nx   = '0;
        state_nx = S_IDLE;
      end
    endcase
    if (capture) begin
      state_nx = S_LOAD;
      idx_nx   = '0;
      cyc_nx   = '0;
    end
    // Abort overrides everything, including a new song in the same cycle.
    if (np.stop) begin
      state_nx = S_IDLE;
      idx_nx   = '0;
      cyc_nx   = '0;
    end
  end

  assign tone_en = (state == S_TONE) && (note.pitch != 4'h0) && (note.pitch != 4'hF);

  // Clearing on stop/restart keeps the buzzer low on the edge that leaves TONE.
  tone_gen u_tone (
    .clk         (clk),
    .rst         (rst),
    .en          (tone_en),
    .clr         (note_end || np.stop || np.rx_done),
    .half_period (pitch_half_period(note.pitch)),
    .buzzer      (np.buzzer)
  );

  assign np.busy     = (state == S_LOAD) || (state == S_TONE) || (state == S_GAP);
  assign np.done     = (state == S_FINISH);
  assign np.note_idx = note_idx;

  logic unused_ok;
  assign unused_ok = ^{NOTE_TERM, 32'(GAP_CYCLES)};
endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player: fast instance (100-cycle beat) for sequencing,
// slow instance (400-cycle beat) for tone toggling and stop.
module tb_note_player;
  import note_pkg::*;
`ifdef NOTE_PLAYER_GAP_EN
  localparam int G = 50;
`else
  localparam int G = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_err    = 0;
  int   done_f = 0, done_s = 0, tog_f = 0;
  logic buz_q  = 1'b0;
  int   dc, tc;

  note_player_if bus_f ();
  note_player_if bus_s ();

  note_player #(.BEAT_CYCLES(100), .GAP_CYCLES(50)) u_dut  (.clk(clk), .rst(rst), .np(bus_f));
  note_player #(.BEAT_CYCLES(400), .GAP_CYCLES(50)) u_slow (.clk(clk), .rst(rst), .np(bus_s));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus_f.done) done_f <= done_f + 1;
    if (bus_s.done) done_s <= done_s + 1;
    if (bus_f.buzzer != buz_q) tog_f <= tog_f + 1;
    buz_q <= bus_f.buzzer;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_f(input logic [BUF_W-1:0] b, input logic [9:0] len);
    bus_f.data_buffer = b;
    bus_f.data_length = len;
    bus_f.rx_done     = 1'b1;
    tick(1);
    bus_f.rx_done     = 1'b0;
    bus_f.data_buffer = '0;
    bus_f.data_length = '0;
  endtask

  initial begin
    bus_f.rx_done = 1'b0; bus_f.data_length = '0; bus_f.data_buffer = '0; bus_f.stop = 1'b0;
    bus_s.rx_done = 1'b0; bus_s.data_length = '0; bus_s.data_buffer = '0; bus_s.stop = 1'b0;
    #12;
    chk("rst_busy",   32'(bus_f.busy),     0);
    chk("rst_done",   32'(bus_f.done),     0);
    chk("rst_buzzer", 32'(bus_f.buzzer),   0);
    chk("rst_idx",    32'(bus_f.note_idx), 0);
    rst = 1'b0;
    tick(1);

    // one A4 note, one beat
    dc = done_f; tc = tog_f;
    send_f(BUF_W'(16'h0060), 10'd2);
    chk("t1_load_busy", 32'(bus_f.busy), 1);
    tick(1);
    chk("t1_idx",  32'(bus_f.note_idx), 0);
    chk("t1_busy", 32'(bus_f.busy), 1);
    tick(99);
    chk("t1_last_busy", 32'(bus_f.busy), 1);
    chk("t1_last_buz",  32'(bus_f.buzzer), 0);
    tick(1);
    chk("t1_done", 32'(bus_f.done), 1);
    chk("t1_idle", 32'(bus_f.busy), 0);
    tick(1);
    chk("t1_done_clr", 32'(bus_f.done), 0);
    chk("t1_done_cnt", 32'(done_f - dc), 1);
    chk("t1_toggles",  32'(tog_f - tc), 0);

    // two notes: C4 for 2 beats, rest for 3 beats
    dc = done_f;
    send_f(BUF_W'(16'h1102), 10'd3);
    tick(200);
    chk("t2_n0_end_idx", 32'(bus_f.note_idx), 0);
    chk("t2_n0_busy",    32'(bus_f.busy), 1);
`ifdef NOTE_PLAYER_GAP_EN
    tick(1);
    chk("t2_gap_idx", 32'(bus_f.note_idx), 0);
    chk("t2_gap_buz", 32'(bus_f.buzzer), 0);
    chk("t2_gap_busy", 32'(bus_f.busy), 1);
    tick(49);
    chk("t2_gap_last_idx", 32'(bus_f.note_idx), 0);
    tick(1);
`else
    tick(1);
`endif
    chk("t2_n1_idx", 32'(bus_f.note_idx), 1);
    chk("t2_n1_buz", 32'(bus_f.buzzer), 0);
    tick(299);
    chk("t2_n1_end_idx", 32'(bus_f.note_idx), 1);
    chk("t2_n1_end_busy", 32'(bus_f.busy), 1);
    tick(1);
    chk("t2_done", 32'(bus_f.done), 1);
    tick(1);
    chk("t2_done_cnt", 32'(done_f - dc), 1);

    // terminator only
    dc = done_f; tc = tog_f;
    send_f('0, 10'd1);
    chk("t3_busy", 32'(bus_f.busy), 1);
    chk("t3_nodone", 32'(bus_f.done), 0);
    tick(1);
    chk("t3_done", 32'(bus_f.done), 1);
    chk("t3_idle", 32'(bus_f.busy), 0);
    tick(1);
    chk("t3_done_clr", 32'(bus_f.done), 0);
    chk("t3_toggles", 32'(tog_f - tc), 0);

    // restart mid-song with a new one-note song
    dc = done_f;
    send_f(BUF_W'(16'h1102), 10'd3);
    tick(300);
    chk("t4_old_idx", 32'(bus_f.note_idx), 1);
    send_f(BUF_W'(16'h0030), 10'd2);
    chk("t4_re_idx",  32'(bus_f.note_idx), 0);
    chk("t4_re_busy", 32'(bus_f.busy), 1);
    tick(100);
    chk("t4_new_busy", 32'(bus_f.busy), 1);
    tick(1);
    chk("t4_new_done", 32'(bus_f.done), 1);
    tick(1);
    chk("t4_done_cnt", 32'(done_f - dc), 1);

    // reset mid-song
    dc = done_f;
    send_f(BUF_W'(16'h1102), 10'd3);
    tick(50);
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", 32'(bus_f.busy), 0);
    chk("t5_rst_buz",  32'(bus_f.buzzer), 0);
    #1;
    rst = 1'b0;
    tick(600);
    chk("t5_no_resume", 32'(bus_f.busy), 0);
    chk("t5_done_cnt",  32'(done_f - dc), 0);

    // slow instance: B5 toggling across notes, then stop in the second note
    dc = done_s;
    bus_s.data_buffer = BUF_W'(24'hEFEFEF);
    bus_s.data_length = 10'd4;
    bus_s.rx_done     = 1'b1;
    tick(1);
    bus_s.rx_done     = 1'b0;
    bus_s.data_buffer = '0;
    bus_s.data_length = '0;
    tick(6074);
    chk("s_pre_toggle", 32'(bus_s.buzzer), 0);
    tick(1);
    chk("s_toggle", 32'(bus_s.buzzer), 1);
    tick(325);
    chk("s_n0_end_buz", 32'(bus_s.buzzer), 1);
    tick(1 + G);
    chk("s_n1_idx",   32'(bus_s.note_idx), 1);
    chk("s_n1_start", 32'(bus_s.buzzer), 0);
    tick(6073);
    chk("s_n1_pre", 32'(bus_s.buzzer), 0);
    tick(1);
    chk("s_n1_toggle", 32'(bus_s.buzzer), 1);
    bus_s.stop = 1'b1;
    tick(1);
    chk("s_stop_busy", 32'(bus_s.busy), 0);
    chk("s_stop_buz",  32'(bus_s.buzzer), 0);
    chk("s_stop_done", 32'(bus_s.done), 0);
    bus_s.stop = 1'b0;
    tick(5);
    chk("s_stop_idle", 32'(bus_s.busy), 0);
    chk("s_done_cnt",  32'(done_s - dc), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
